// File: rtl/digit_scan_pkg.sv
// rtl/digit_scan_pkg.sv - shared types and constants for the display scan controller
package digit_scan_pkg;

    typedef enum logic [1:0] {
        OFF   = 2'd0,
        GUARD = 2'd1,
        ON    = 2'd2
    } scan_state_t;

    localparam int NDIG = 4;
    localparam logic [NDIG-1:0] AN_OFF = 4'b1111;

    // Width that holds both the lit count and the guard count.
    function automatic int cnt_width(input int div, input int guard);
        int m;
        m = (div > guard) ? div : guard;
        if (m < 2) begin
            m = 2;
        end
        return $clog2(m);
    endfunction

endpackage

// File: rtl/digit_scan_cnt_mod.sv
// rtl/digit_scan_cnt_mod.sv - clearable, enabled mod-N counter with terminal-count flag
module cnt_mod #(
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    assign tc  = (cnt_q == last);
    assign cnt = cnt_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (inc) begin
            cnt_d = tc ? '0 : cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/digit_scan.sv
// rtl/digit_scan.sv - 4-digit 7-segment scan controller with guard interval and leading-zero blanking
module digit_scan
    import digit_scan_pkg::scan_state_t, digit_scan_pkg::NDIG, digit_scan_pkg::AN_OFF, digit_scan_pkg::cnt_width;
#(
    parameter int DIV   = 100000,
    parameter int GUARD = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic [4*NDIG-1:0]   digits,
    input  logic [NDIG-1:0]     dp_in,
    input  logic                blank_lz,
    output logic [1:0]          sel,
    output logic [3:0]          digit,
    output logic [NDIG-1:0]     an,
    output logic                dp,
    output logic                tick
);

    localparam int CW = cnt_width(DIV, GUARD);
    localparam logic [CW-1:0] ON_LAST    = CW'(DIV - 1);
    localparam logic [CW-1:0] GUARD_LAST = CW'((GUARD > 0) ? GUARD - 1 : 0);
    localparam scan_state_t   SLOT_ENTRY = (GUARD > 0) ? digit_scan_pkg::GUARD : digit_scan_pkg::ON;

    scan_state_t state_q, state_d;
    logic [1:0]  idx_q, idx_d;

    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_last;
    logic          cnt_clr;
    logic          tc;

    logic [1:0]      sel_q, sel_d;
    logic [3:0]      digit_q, digit_d;
    logic [NDIG-1:0] an_q, an_d;
    logic            dp_q, dp_d;
    logic            tick_q, tick_d;
    logic            blank_q, blank_d;
    logic            dp_cap_q, dp_cap_d;

    logic [4*NDIG-1:0] upper;
    logic [3:0]        nib;
    logic              first_on;
    logic              blank_c;
    logic              blank_now;
    logic              dp_now;
    logic              lit;

    assign cnt_clr  = !en || (state_q == digit_scan_pkg::OFF);
    assign cnt_last = (state_q == digit_scan_pkg::ON) ? ON_LAST : GUARD_LAST;

    cnt_mod #(.W(CW)) u_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (cnt_clr),
        .inc   (!cnt_clr),
        .last  (cnt_last),
        .cnt   (cnt),
        .tc    (tc)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= digit_scan_pkg::OFF;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        if (!en) begin
            state_d = digit_scan_pkg::OFF;
            idx_d   = '0;
        end else begin
            case (state_q)
                digit_scan_pkg::OFF:   state_d = SLOT_ENTRY;
                digit_scan_pkg::GUARD: if (tc) state_d = digit_scan_pkg::ON;
                digit_scan_pkg::ON: begin
                    if (tc) begin
                        state_d = SLOT_ENTRY;
                        idx_d   = idx_q + 2'd1;
                    end
                end
                default: state_d = digit_scan_pkg::OFF;
            endcase
        end
    end

    // Outputs lag the FSM by one register stage; the slot's values are captured in its first ON cycle.
    always_comb begin
        upper     = digits >> {idx_q, 2'b00};
        nib       = digits[{idx_q, 2'b00} +: 4];
        blank_c   = blank_lz && (idx_q != 2'd0) && (upper == '0);
        first_on  = en && (state_q == digit_scan_pkg::ON) && (cnt == '0);
        blank_now = first_on ? blank_c : blank_q;
        dp_now    = first_on ? ~dp_in[idx_q] : dp_cap_q;
        lit       = en && (state_q == digit_scan_pkg::ON) && !blank_now;

        blank_d  = blank_now;
        dp_cap_d = dp_now;
        digit_d  = first_on ? nib : digit_q;
        an_d     = lit ? ~(NDIG'(1) << idx_q) : AN_OFF;
        dp_d     = lit ? dp_now : 1'b1;
        sel_d    = en ? idx_q : 2'd0;
        // The FSM index only ever moves by one, so a difference marks an advance.
        tick_d   = en && (idx_q != sel_q);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_q    <= '0;
            digit_q  <= '0;
            an_q     <= AN_OFF;
            dp_q     <= 1'b1;
            tick_q   <= 1'b0;
            blank_q  <= 1'b0;
            dp_cap_q <= 1'b1;
        end else begin
            sel_q    <= sel_d;
            digit_q  <= digit_d;
            an_q     <= an_d;
            dp_q     <= dp_d;
            tick_q   <= tick_d;
            blank_q  <= blank_d;
            dp_cap_q <= dp_cap_d;
        end
    end

    assign sel   = sel_q;
    assign digit = digit_q;
    assign an    = an_q;
    assign dp    = dp_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_digit_scan.sv
// tb/tb_digit_scan.sv - directed self-checking bench for digit_scan (DIV=4, GUARD=2 and GUARD=0)
module tb_digit_scan;

    localparam int DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic        en2;
    logic [15:0] digits;
    logic [3:0]  dp_in;
    logic        blank_lz;

    logic [1:0]  sel, sel2;
    logic [3:0]  digit, digit2;
    logic [3:0]  an, an2;
    logic        dp, dp2;
    logic        tick, tick2;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    digit_scan #(.DIV(4), .GUARD(2)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .digits(digits), .dp_in(dp_in), .blank_lz(blank_lz),
        .sel(sel), .digit(digit), .an(an), .dp(dp), .tick(tick)
    );

    digit_scan #(.DIV(4), .GUARD(0)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .en(en2), .digits(digits), .dp_in(dp_in), .blank_lz(blank_lz),
        .sel(sel2), .digit(digit2), .an(an2), .dp(dp2), .tick(tick2)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Entered at the sample where tick announced slot s; leaves at the sample announcing s+1.
    task automatic slot(input logic [1:0] s, input logic [3:0] exp_digit, input logic [3:0] exp_an,
                        input logic exp_dp, input logic [15:0] mid_digits);
        logic [1:0] nxt;
        nxt = s + 2'd1;
        step();
        check($sformatf("gap_an s%0d", s), an, 4'hF);
        check($sformatf("gap_tick s%0d", s), tick, 1'b0);
        for (int k = 0; k < DIV; k++) begin
            step();
            check($sformatf("lit_an s%0d c%0d", s, k), an, exp_an);
            check($sformatf("lit_digit s%0d c%0d", s, k), digit, exp_digit);
            check($sformatf("lit_dp s%0d c%0d", s, k), dp, exp_dp);
            check($sformatf("lit_sel s%0d c%0d", s, k), sel, s);
            check($sformatf("lit_tick s%0d c%0d", s, k), tick, 1'b0);
            if (k == 1) digits = mid_digits;
        end
        step();
        check($sformatf("adv_tick s%0d", s), tick, 1'b1);
        check($sformatf("adv_sel s%0d", s), sel, nxt);
        check($sformatf("adv_an s%0d", s), an, 4'hF);
    endtask

    logic [3:0] g0_an  [4] = '{4'hD, 4'hB, 4'h7, 4'hE};
    logic [3:0] g0_dig [4] = '{4'h3, 4'h2, 4'h1, 4'h4};
    logic       g0_dp  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0] g0_sel [4] = '{2'd1, 2'd2, 2'd3, 2'd0};

    initial begin
        rst_n = 1'b0; en = 1'b1; en2 = 1'b0;
        digits = 16'h1234; dp_in = 4'b0000; blank_lz = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_an", an, 4'hF);
        check("rst_sel", sel, 2'd0);
        check("rst_dp", dp, 1'b1);
        check("rst_tick", tick, 1'b0);
        check("rst_digit", digit, 4'h0);

        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("boot_dark", an, 4'hF);
        end
        for (int i = 0; i < DIV; i++) begin
            step();
            check("boot_an", an, 4'hE);
            check("boot_digit", digit, 4'h4);
            check("boot_sel", sel, 2'd0);
        end
        step();
        check("boot_tick", tick, 1'b1);
        check("boot_sel_adv", sel, 2'd1);

        slot(2'd1, 4'h3, 4'hD, 1'b1, 16'h1234);
        slot(2'd2, 4'h2, 4'hB, 1'b1, 16'h1234);
        slot(2'd3, 4'h1, 4'h7, 1'b1, 16'h1234);
        slot(2'd0, 4'h4, 4'hE, 1'b1, 16'h1234);

        blank_lz = 1'b1; digits = 16'h0070;
        slot(2'd1, 4'h7, 4'hD, 1'b1, 16'h0070);
        slot(2'd2, 4'h0, 4'hF, 1'b1, 16'h0070);
        slot(2'd3, 4'h0, 4'hF, 1'b1, 16'h0070);
        slot(2'd0, 4'h0, 4'hE, 1'b1, 16'h0000);
        slot(2'd1, 4'h0, 4'hF, 1'b1, 16'h0000);
        slot(2'd2, 4'h0, 4'hF, 1'b1, 16'h0000);
        slot(2'd3, 4'h0, 4'hF, 1'b1, 16'h0000);
        slot(2'd0, 4'h0, 4'hE, 1'b1, 16'h0000);

        blank_lz = 1'b0; digits = 16'h1234;
        slot(2'd1, 4'h3, 4'hD, 1'b1, 16'h5678);
        slot(2'd2, 4'h6, 4'hB, 1'b1, 16'h5678);
        slot(2'd3, 4'h5, 4'h7, 1'b1, 16'h5678);
        slot(2'd0, 4'h8, 4'hE, 1'b1, 16'h1234);

        dp_in = 4'b0101;
        slot(2'd1, 4'h3, 4'hD, 1'b1, 16'h1234);
        slot(2'd2, 4'h2, 4'hB, 1'b0, 16'h1234);
        slot(2'd3, 4'h1, 4'h7, 1'b1, 16'h1234);
        slot(2'd0, 4'h4, 4'hE, 1'b0, 16'h1234);

        dp_in = 4'b0000;
        slot(2'd1, 4'h3, 4'hD, 1'b1, 16'h1234);
        step();
        step(); check("drop_pre_an", an, 4'hB);
        step();
        en = 1'b0;
        step();
        check("drop_an", an, 4'hF);
        check("drop_sel", sel, 2'd0);
        check("drop_tick", tick, 1'b0);
        step(); check("drop_hold_an", an, 4'hF);

        en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("restart_dark", an, 4'hF);
        end
        for (int i = 0; i < DIV; i++) begin
            step();
            check("restart_an", an, 4'hE);
            check("restart_digit", digit, 4'h4);
        end
        en = 1'b0;
        step();
        check("collide_tick", tick, 1'b0);
        check("collide_sel", sel, 2'd0);
        check("collide_an", an, 4'hF);

        en = 1'b1;
        for (int i = 0; i < 3; i++) step();
        step(); check("prereset_an", an, 4'hE);
        #2 rst_n = 1'b0;
        #1;
        check("async_an", an, 4'hF);
        check("async_sel", sel, 2'd0);
        check("async_digit", digit, 4'h0);
        check("async_dp", dp, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(); check("rerun_dark", an, 4'hF);
        end
        step();
        check("rerun_an", an, 4'hE);
        check("rerun_digit", digit, 4'h4);

        dp_in = 4'b0101;
        en2 = 1'b1;
        step(); check("g0_dark", an2, 4'hF);
        for (int i = 0; i < DIV; i++) begin
            step();
            check("g0_first_an", an2, 4'hE);
            check("g0_first_digit", digit2, 4'h4);
            check("g0_first_dp", dp2, 1'b0);
            check("g0_first_tick", tick2, 1'b0);
        end
        for (int s = 0; s < 4; s++) begin
            for (int k = 0; k < DIV; k++) begin
                step();
                check($sformatf("g0_an s%0d c%0d", s, k), an2, g0_an[s]);
                check($sformatf("g0_digit s%0d c%0d", s, k), digit2, g0_dig[s]);
                check($sformatf("g0_dp s%0d c%0d", s, k), dp2, g0_dp[s]);
                check($sformatf("g0_sel s%0d c%0d", s, k), sel2, g0_sel[s]);
                check($sformatf("g0_tick s%0d c%0d", s, k), tick2, (k == 0) ? 1'b1 : 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
